// File: rtl/gp9001_host_if.sv
`default_nettype none
// ============================================================================
// Module   : gp9001_host_if
// Purpose  : Host-side command executor for the GP9001 video controller.
//            Executes one level-held CPU operation per 4-phase handshake:
//            register select/write, VRAM pointer load, VRAM write (post-
//            increment), VRAM read (with or without post-increment).
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   CLK96, RESET96          clock, synchronous active-high reset
//   OP_*                    level-held operation strobes from the CPU block
//   CPU_DIN[15:0]           CPU write data
//   ACK                     4-phase acknowledge (high in DONE while strobed)
//   DOUT[15:0]              last read result
//   VRAM_REQ/GNT/WE/ADDR/   arbitrated VRAM port shared with the renderer
//   VRAM_DIN/VRAM_Q
//   REG_BUS[16*NREGS-1:0]   flat register file, reg i at [16i+15:16i]
// ============================================================================
module gp9001_host_if #(
  parameter int AW     = 14,
  parameter int NREGS  = 32,
  parameter int RD_LAT = 1
) (
  input  logic                  CLK96,
  input  logic                  RESET96,
  input  logic                  OP_SELECT_REG,
  input  logic                  OP_WRITE_REG,
  input  logic                  OP_WRITE_RAM,
  input  logic                  OP_READ_RAM_H,
  input  logic                  OP_READ_RAM_L,
  input  logic                  OP_SET_RAM_PTR,
  input  logic [15:0]           CPU_DIN,
  output logic                  ACK,
  output logic [15:0]           DOUT,
  output logic                  VRAM_REQ,
  input  logic                  VRAM_GNT,
  output logic                  VRAM_WE,
  output logic [AW-1:0]         VRAM_ADDR,
  output logic [15:0]           VRAM_DIN,
  input  logic [15:0]           VRAM_Q,
  output logic [16*NREGS-1:0]   REG_BUS
);

  localparam int IW = (NREGS > 1) ? $clog2(NREGS) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RDWAIT = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_PTR  = 3'd1,
    OP_SEL  = 3'd2,
    OP_WREG = 3'd3,
    OP_WRAM = 3'd4,
    OP_RDH  = 3'd5,
    OP_RDL  = 3'd6
  } op_t;

  state_t          state_q, state_d;
  op_t             op_q, new_op;
  logic [AW-1:0]   ptr;
  logic [7:0]      reg_sel;
  logic [15:0]     regs [NREGS];
  logic [1:0]      lat_cnt;
  logic            any_strobe;
  logic            accept, grant, rd_done, ack_d;
  logic            sel_ok;

  assign any_strobe = OP_SET_RAM_PTR | OP_SELECT_REG | OP_WRITE_REG |
                      OP_WRITE_RAM | OP_READ_RAM_H | OP_READ_RAM_L;

  // Register index beyond the file silently discards the write.
  assign sel_ok = int'(reg_sel) < NREGS;

  // Fixed-priority pick of a single operation when strobes overlap.
  always_comb begin
    new_op = OP_NONE;
    if      (OP_SET_RAM_PTR) new_op = OP_PTR;
    else if (OP_SELECT_REG)  new_op = OP_SEL;
    else if (OP_WRITE_REG)   new_op = OP_WREG;
    else if (OP_WRITE_RAM)   new_op = OP_WRAM;
    else if (OP_READ_RAM_H)  new_op = OP_RDH;
    else if (OP_READ_RAM_L)  new_op = OP_RDL;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    grant   = 1'b0;
    rd_done = 1'b0;
    ack_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (new_op != OP_NONE && !ACK) begin
          accept  = 1'b1;
          state_d = (new_op == OP_WRAM || new_op == OP_RDH || new_op == OP_RDL)
                    ? S_ACCESS : S_DONE;
        end
      end
      S_ACCESS: begin
        if (VRAM_GNT && VRAM_REQ) begin
          grant   = 1'b1;
          state_d = (op_q == OP_WRAM) ? S_DONE : S_RDWAIT;
        end
      end
      S_RDWAIT: begin
        if (lat_cnt == 2'd0) begin
          rd_done = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // ACK follows the strobes; dropping them all releases the handshake.
        ack_d = any_strobe;
        if (!any_strobe) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK96) begin
    if (RESET96) begin
      state_q   <= S_IDLE;
      op_q      <= OP_NONE;
      ACK       <= 1'b0;
      DOUT      <= '0;
      VRAM_REQ  <= 1'b0;
      VRAM_WE   <= 1'b0;
      VRAM_ADDR <= '0;
      VRAM_DIN  <= '0;
      ptr       <= '0;
      reg_sel   <= '0;
      lat_cnt   <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      state_q <= state_d;
      ACK     <= ack_d;

      if (accept) begin
        op_q <= new_op;
        case (new_op)
          OP_PTR:  ptr     <= CPU_DIN[AW-1:0];
          OP_SEL:  reg_sel <= CPU_DIN[7:0];
          OP_WREG: if (sel_ok) regs[reg_sel[IW-1:0]] <= CPU_DIN;
          OP_WRAM, OP_RDH, OP_RDL: begin
            VRAM_REQ  <= 1'b1;
            VRAM_WE   <= (new_op == OP_WRAM);
            VRAM_ADDR <= ptr;
            VRAM_DIN  <= CPU_DIN;
          end
          default: ;
        endcase
      end

      if (grant) begin
        VRAM_REQ <= 1'b0;
        VRAM_WE  <= 1'b0;
        lat_cnt  <= 2'(RD_LAT - 1);
        if (op_q == OP_WRAM) ptr <= ptr + 1'b1;
      end

      if (state_q == S_RDWAIT && !rd_done) lat_cnt <= lat_cnt - 2'd1;

      if (rd_done) begin
        DOUT <= VRAM_Q;
        if (op_q == OP_RDL) ptr <= ptr + 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NREGS; i++) begin : g_regbus
    assign REG_BUS[16*i +: 16] = regs[i];
  end

endmodule
`default_nettype wire

// File: tb/tb_gp9001_host_if.sv
`default_nettype none
// ============================================================================
// Module   : tb_gp9001_host_if
// Purpose  : Self-checking bench for gp9001_host_if. Two instances (RD_LAT=1
//            and RD_LAT=2) receive identical stimulus, each with its own VRAM
//            model. Expected read data and VRAM writes are queued when an op
//            is driven and compared when the handshake completes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gp9001_host_if;

  localparam int AW    = 14;
  localparam int NREGS = 32;

  // strobe bit map: [0]SET_RAM_PTR [1]SELECT_REG [2]WRITE_REG
  //                 [3]WRITE_RAM   [4]READ_RAM_H [5]READ_RAM_L
  localparam logic [5:0] M_PTR = 6'b000001;
  localparam logic [5:0] M_SEL = 6'b000010;
  localparam logic [5:0] M_WRG = 6'b000100;
  localparam logic [5:0] M_WRM = 6'b001000;
  localparam logic [5:0] M_RDH = 6'b010000;
  localparam logic [5:0] M_RDL = 6'b100000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic [5:0]          strb;
  logic [15:0]         din;
  logic                gnt;
  logic                ack_a, ack_b, req_a, req_b, we_a, we_b;
  logic [15:0]         dout_a, dout_b, wd_a, wd_b, q_a, q_b;
  logic [AW-1:0]       adr_a, adr_b;
  logic [16*NREGS-1:0] rb_a, rb_b;

  gp9001_host_if #(.AW(AW), .NREGS(NREGS), .RD_LAT(1)) u_dut_a (
    .CLK96(clk), .RESET96(rst),
    .OP_SELECT_REG(strb[1]), .OP_WRITE_REG(strb[2]), .OP_WRITE_RAM(strb[3]),
    .OP_READ_RAM_H(strb[4]), .OP_READ_RAM_L(strb[5]), .OP_SET_RAM_PTR(strb[0]),
    .CPU_DIN(din), .ACK(ack_a), .DOUT(dout_a),
    .VRAM_REQ(req_a), .VRAM_GNT(gnt), .VRAM_WE(we_a), .VRAM_ADDR(adr_a),
    .VRAM_DIN(wd_a), .VRAM_Q(q_a), .REG_BUS(rb_a)
  );

  gp9001_host_if #(.AW(AW), .NREGS(NREGS), .RD_LAT(2)) u_dut_b (
    .CLK96(clk), .RESET96(rst),
    .OP_SELECT_REG(strb[1]), .OP_WRITE_REG(strb[2]), .OP_WRITE_RAM(strb[3]),
    .OP_READ_RAM_H(strb[4]), .OP_READ_RAM_L(strb[5]), .OP_SET_RAM_PTR(strb[0]),
    .CPU_DIN(din), .ACK(ack_b), .DOUT(dout_b),
    .VRAM_REQ(req_b), .VRAM_GNT(gnt), .VRAM_WE(we_b), .VRAM_ADDR(adr_b),
    .VRAM_DIN(wd_b), .VRAM_Q(q_b), .REG_BUS(rb_b)
  );

  // VRAM models: one-cycle read pipe for A, two-cycle for B; writes logged.
  logic [15:0] mem_a [0:(1<<AW)-1];
  logic [15:0] mem_b [0:(1<<AW)-1];
  logic [15:0] rp_a, rp_b0, rp_b1;
  logic [29:0] log_a [$];
  logic [29:0] log_b [$];

  always @(posedge clk) begin
    if (req_a && gnt) begin
      if (we_a) begin
        mem_a[adr_a] <= wd_a;
        log_a.push_back({adr_a, wd_a});
      end else rp_a <= mem_a[adr_a];
    end
  end

  always @(posedge clk) begin
    if (req_b && gnt) begin
      if (we_b) begin
        mem_b[adr_b] <= wd_b;
        log_b.push_back({adr_b, wd_b});
      end else rp_b0 <= mem_b[adr_b];
    end
    rp_b1 <= rp_b0;
  end

  assign q_a = rp_a;
  assign q_b = rp_b1;

  // Bench-side model and scoreboard
  int                  tests = 0;
  int                  fails = 0;
  logic [AW-1:0]       mptr;
  logic [7:0]          msel;
  logic [16*NREGS-1:0] mregs;
  logic [15:0]         edout;
  logic [29:0]         wq [$];
  logic [15:0]         dq [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_rb(input string nm);
    tests++;
    if (rb_a !== mregs || rb_b !== mregs) begin
      fails++;
      $display("FAIL %s: reg_bus a=%h b=%h expected %h", nm, rb_a, rb_b, mregs);
    end
  endtask

  task automatic drive(input logic [5:0] m, input logic [15:0] d, input logic [15:0] exp_dout);
    @(negedge clk);
    din  = d;
    strb = m;
    dq.push_back(exp_dout);
    if (m[0]) mptr = d[AW-1:0];
    else if (m[1]) msel = d[7:0];
    else if (m[2]) begin
      if (int'(msel) < NREGS) mregs[int'(msel)*16 +: 16] = d;
    end else if (m[3]) begin
      wq.push_back({mptr, d});
      mptr = mptr + 1'b1;
    end else if (m[5]) mptr = mptr + 1'b1;
  endtask

  task automatic complete(input string nm, input int lat_a, input int lat_b);
    int n = 0;
    int la = 0;
    int lb = 0;
    logic [29:0] e, g;
    logic [15:0] ed;
    while ((la == 0 || lb == 0) && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (ack_a && la == 0) la = n;
      if (ack_b && lb == 0) lb = n;
    end
    chk($sformatf("%s ack_a seen", nm), 64'(la != 0), 64'd1);
    chk($sformatf("%s ack_b seen", nm), 64'(lb != 0), 64'd1);
    if (lat_a > 0) begin
      chk($sformatf("%s ack_a latency", nm), 64'(la), 64'(lat_a));
      chk($sformatf("%s ack_b latency", nm), 64'(lb), 64'(lat_b));
    end
    ed = dq.pop_front();
    chk($sformatf("%s dout_a", nm), 64'(dout_a), 64'(ed));
    chk($sformatf("%s dout_b", nm), 64'(dout_b), 64'(ed));
    while (wq.size() > 0) begin
      e = wq.pop_front();
      g = (log_a.size() > 0) ? log_a.pop_front() : 'x;
      chk($sformatf("%s vram write a", nm), 64'(g), 64'(e));
      g = (log_b.size() > 0) ? log_b.pop_front() : 'x;
      chk($sformatf("%s vram write b", nm), 64'(g), 64'(e));
    end
    chk($sformatf("%s stray writes", nm), 64'(log_a.size() + log_b.size()), 64'd0);
    chk_rb(nm);
    @(negedge clk);
    strb = '0;
    @(posedge clk); #1;
    chk($sformatf("%s ack drop", nm), {62'd0, ack_a, ack_b}, 64'd0);
  endtask

  task automatic do_op(input string nm, input logic [5:0] m, input logic [15:0] d,
                       input logic [15:0] exp_dout, input int lat_a, input int lat_b);
    drive(m, d, exp_dout);
    complete(nm, lat_a, lat_b);
  endtask

  typedef struct {
    logic [5:0]  m;
    logic [15:0] d;
    logic [15:0] dout;
    int          la;
    int          lb;
  } vec_t;

  vec_t tv [16];

  initial begin
    logic seen;

    tv[0]  = '{M_SEL, 16'h0003, 16'h0000, 2, 2};
    tv[1]  = '{M_WRG, 16'hBEEF, 16'h0000, 2, 2};
    tv[2]  = '{M_SEL, 16'h0040, 16'h0000, 2, 2};
    tv[3]  = '{M_WRG, 16'hFFFF, 16'h0000, 2, 2};
    tv[4]  = '{M_PTR, 16'h0100, 16'h0000, 2, 2};
    tv[5]  = '{M_WRM, 16'hAAAA, 16'h0000, 3, 3};
    tv[6]  = '{M_WRM, 16'h5555, 16'h0000, 3, 3};
    tv[7]  = '{M_PTR, 16'h0100, 16'h0000, 2, 2};
    tv[8]  = '{M_RDH, 16'h0000, 16'hAAAA, 4, 5};
    tv[9]  = '{M_RDL, 16'h0000, 16'hAAAA, 4, 5};
    tv[10] = '{M_RDL, 16'h0000, 16'h5555, 4, 5};
    tv[11] = '{M_WRM, 16'h7777, 16'h5555, 3, 3};
    tv[12] = '{M_SEL, 16'h001F, 16'h5555, 2, 2};
    tv[13] = '{M_WRG, 16'h1357, 16'h5555, 2, 2};
    tv[14] = '{M_SEL, 16'h0020, 16'h5555, 2, 2};
    tv[15] = '{M_WRG, 16'h2468, 16'h5555, 2, 2};

    rst = 1'b1; strb = '0; din = '0; gnt = 1'b1;
    mptr = '0; msel = '0; mregs = '0; edout = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset ack", {62'd0, ack_a, ack_b}, 64'd0);
    chk("reset dout_a", 64'(dout_a), 64'd0);
    chk("reset dout_b", 64'(dout_b), 64'd0);
    chk("reset req", {62'd0, req_a, req_b}, 64'd0);
    chk_rb("reset reg_bus");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      do_op($sformatf("vec%0d", i), tv[i].m, tv[i].d, tv[i].dout, tv[i].la, tv[i].lb);
      edout = tv[i].dout;
    end

    // Grant withheld for 5 cycles, then released; pointer wraps at 0x3FFF.
    do_op("ptr 3fff", M_PTR, 16'h3FFF, edout, 2, 2);
    gnt = 1'b0;
    drive(M_WRM, 16'h1234, edout);
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (ack_a || ack_b) seen = 1'b1;
    end
    chk("gnt low ack", 64'(seen), 64'd0);
    chk("gnt low req/we", {60'd0, req_a, req_b, we_a, we_b}, 64'hF);
    chk("gnt low addr_a", 64'(adr_a), 64'h3FFF);
    chk("gnt low addr_b", 64'(adr_b), 64'h3FFF);
    chk("gnt low din_a", 64'(wd_a), 64'h1234);
    @(negedge clk);
    gnt = 1'b1;
    complete("gnt release", 2, 2);
    do_op("wrap write", M_WRM, 16'h4321, edout, 3, 3);

    // Overlapping strobes: pointer load wins, no VRAM access.
    do_op("ptr+wram", M_PTR | M_WRM, 16'h0200, edout, 2, 2);
    do_op("after ptr+wram", M_WRM, 16'h9999, edout, 3, 3);

    // Reset while waiting for a grant: access abandoned, no write.
    gnt = 1'b0;
    @(negedge clk);
    din = 16'hDEAD;
    strb = M_WRM;
    @(posedge clk); #1;
    chk("access req", {62'd0, req_a, req_b}, 64'd3);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("reset in access req/we/ack", {58'd0, req_a, req_b, we_a, we_b, ack_a, ack_b}, 64'd0);
    @(negedge clk);
    rst = 1'b0; strb = '0; gnt = 1'b1;
    mptr = '0; msel = '0; mregs = '0; edout = '0;
    @(posedge clk); #1;
    chk_rb("reset in access reg_bus");
    chk("reset in access dout", {dout_a, dout_b}, 64'd0);
    chk("reset in access no write", 64'(log_a.size() + log_b.size()), 64'd0);
    do_op("post-reset write", M_WRM, 16'h0F0F, edout, 3, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gp9001_host_if.md
Name: gp9001_host_if

Overview:
Host-side command executor for the GP9001 video controller. It consumes the level-held operation strobes from the 68k CPU block and answers with GP9001ACK and GP9001_DOUT. It owns the register-select latch, the register file and the auto-incrementing VRAM pointer. VRAM accesses go through an arbitrated port that is shared with the tile/sprite renderer.

Parameters:
AW, 14, VRAM word-address width; the pointer wraps modulo 2^AW.
NREGS, 32, number of 16-bit control registers; index is reg_sel[4:0].
RD_LAT, 1, cycles from the granted read cycle until VRAM_Q is valid (1..3).

Ports:
CLK96  in  1  system clock; all logic on the rising edge.
RESET96  in  1  synchronous, active-high reset.
OP_SELECT_REG  in  1  level; load register index.
OP_WRITE_REG  in  1  level; write the selected register.
OP_WRITE_RAM  in  1  level; write VRAM at the pointer, then increment the pointer.
OP_READ_RAM_H  in  1  level; read VRAM at the pointer, no increment.
OP_READ_RAM_L  in  1  level; read VRAM at the pointer, then increment the pointer.
OP_SET_RAM_PTR  in  1  level; load the pointer.
CPU_DIN  in  16  CPU write data (the CPU block's DOUT).
ACK  out  1  to GP9001ACK; 4-phase acknowledge.
DOUT  out  16  to GP9001_DOUT; last read result.
VRAM_REQ  out  1  host access request to the arbiter.
VRAM_GNT  in  1  the arbiter grants the current cycle.
VRAM_WE  out  1  write qualifier; valid while VRAM_REQ=1.
VRAM_ADDR  out  AW  access address.
VRAM_DIN  out  16  write data.
VRAM_Q  in  16  read data.
REG_BUS  out  16*NREGS  flat register file; register i sits at bits [16i+15:16i].

Behaviour:
- Reset (synchronous): state goes to IDLE. ACK, DOUT, VRAM_REQ, VRAM_WE, VRAM_ADDR, VRAM_DIN, reg_sel, ptr and REG_BUS are all 0. Reset has priority over any op in flight; a pending access is abandoned without a write and without an ACK.
- States: IDLE, ACCESS, RDWAIT, DONE.
- IDLE: wait for any strobe high while ACK=0. If several strobes are high together, execute exactly one, in this priority order: SET_RAM_PTR > SELECT_REG > WRITE_REG > WRITE_RAM > READ_RAM_H > READ_RAM_L. The other strobes are ignored for that handshake. Latch the op code and CPU_DIN.
- SET_RAM_PTR: ptr <= CPU_DIN[AW-1:0]; go to DONE.
- SELECT_REG: reg_sel <= CPU_DIN[7:0]; go to DONE.
- WRITE_REG: if reg_sel < NREGS, regs[reg_sel] <= latched data; otherwise discard the data. Go to DONE.
- Register ops therefore take 1 cycle: a strobe sampled at edge n gives ACK=1 after edge n+1.
- RAM ops: go to ACCESS with VRAM_REQ=1, VRAM_ADDR=ptr, VRAM_WE=(op==WRITE_RAM) and VRAM_DIN=latched data. These outputs are registered and stay stable throughout ACCESS.
- The access happens on the first ACCESS cycle with VRAM_GNT=1. On that edge VRAM_REQ and VRAM_WE drop to 0.
- WRITE_RAM: on the grant edge, ptr <= ptr+1 (modulo 2^AW; 2^AW-1 wraps to 0); go to DONE.
- READ_RAM_H / READ_RAM_L: go to RDWAIT and count RD_LAT cycles. Then DOUT <= VRAM_Q. READ_RAM_L also does ptr <= ptr+1 on that edge. Go to DONE.
- VRAM_GNT may stay low indefinitely; the block holds ACCESS and ACK stays 0. A GNT seen while VRAM_REQ=0 is ignored.
- DONE: ACK=1 and stays 1 while any strobe is high. On the first cycle with all strobes low, ACK <= 0 and the state returns to IDLE.
- A new op is accepted only from IDLE, so back-to-back ops always see at least one ACK-low cycle.
- DOUT changes only on read completion or reset. REG_BUS changes only on WRITE_REG or reset.
- A strobe that drops before ACK is a protocol violation. The op still completes, and DONE exits immediately because all strobes are already low.

Test Plan:
- Reset with all strobes low -> ACK=0, DOUT=0, VRAM_REQ=0, REG_BUS all 0.
- SELECT_REG with CPU_DIN=0x0003, then WRITE_REG with 0xBEEF -> REG_BUS[63:48]=0xBEEF and all other registers 0. Each op's ACK rises 2 edges after its strobe and falls 1 edge after the strobe drops.
- SET_RAM_PTR=0x3FFF, WRITE_RAM 0x1234 with GNT held low for 5 cycles, then GNT=1 -> ACK stays 0 for the 5 cycles. On the grant cycle VRAM_ADDR=0x3FFF, VRAM_WE=1, VRAM_DIN=0x1234. ptr wraps to 0 (a following write targets 0x0000).
- Preload VRAM[0x0100]=0xAAAA and VRAM[0x0101]=0x5555. SET_RAM_PTR=0x0100, then READ_RAM_H, READ_RAM_L, READ_RAM_L -> DOUT is 0xAAAA, 0xAAAA, 0x5555 in turn, leaving ptr=0x0102. Repeat with RD_LAT=2 to confirm the extra cycle.
- SELECT_REG=0x40 (>= NREGS), then WRITE_REG 0xFFFF -> REG_BUS unchanged and ACK still completes. Separately, SET_RAM_PTR and WRITE_RAM asserted together -> only the pointer loads and no VRAM access occurs.
- Assert RESET96 during ACCESS with GNT low -> the next edge gives IDLE, VRAM_REQ=0, ptr=0 and ACK=0, with no VRAM write issued.
